// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD digit type, digit limits and a digit-clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;
    localparam bcd_digit_t BCD_DIGIT_MIN = 4'd0;

    // Non-decimal nibbles (A..F) are treated as 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
    endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// ============================================================================
//  Module      : bcd_digit_step
//  Description : One BCD digit of an up/down ripple step (borrow or carry).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       bin_i,
    input  logic       up_i,
    output bcd_digit_t digit_o,
    output logic       bout_o
);

    always_comb begin
        digit_o = digit_i;
        bout_o  = 1'b0;
        if (bin_i) begin
            if (up_i) begin
                if (digit_i >= BCD_DIGIT_MAX) begin
                    digit_o = BCD_DIGIT_MIN;
                    bout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_DIGIT_MIN) begin
                    digit_o = BCD_DIGIT_MAX;
                    bout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step

`default_nettype wire

// File: rtl/bcd_down_counter.sv
// ============================================================================
//  Module      : bcd_down_counter
//  Description : Multi-digit BCD down counter with load, auto-reload, wrap and
//                expire pulse. Define BCD_UPDOWN_EN to add the up_dn port.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  tick,
    input  logic                  auto_rl,
`ifdef BCD_UPDOWN_EN
    input  logic                  up_dn,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  expire
);

    localparam int              W         = 4 * DIGITS;
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{BCD_DIGIT_MAX}};

    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    reload_q, reload_d;
    logic            expire_q, expire_d;

    logic [W-1:0]    w_load_sat;
    logic [W-1:0]    w_step_val;
    logic [DIGITS:0] w_chain;
    logic            w_up;
    logic            w_zero;

`ifdef BCD_UPDOWN_EN
    assign w_up = up_dn;
`else
    assign w_up = 1'b0;
`endif

    // The least significant digit always steps; borrow/carry ripples upward.
    assign w_chain[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_load_sat[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);

            bcd_digit_step u_step (
                .digit_i (count_q[4*i +: 4]),
                .bin_i   (w_chain[i]),
                .up_i    (w_up),
                .digit_o (w_step_val[4*i +: 4]),
                .bout_o  (w_chain[i+1])
            );
        end
    endgenerate

    assign w_zero = (count_q == '0);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (load) begin
            count_d  = w_load_sat;
            reload_d = w_load_sat;
        end else if (tick) begin
            if (w_up) begin
                // Carry out of the top digit means all-9s rolled over to 0.
                count_d  = w_step_val;
                expire_d = w_chain[DIGITS];
            end else if (!w_zero) begin
                count_d  = w_step_val;
                expire_d = (w_step_val == '0);
            end else if (auto_rl) begin
                count_d  = reload_q;
            end else if (WRAP != 0) begin
                count_d  = ALL_NINES;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    assign count  = count_q;
    assign zero   = w_zero;
    assign expire = expire_q;

endmodule : bcd_down_counter

`default_nettype wire
